// File: rtl/mem_wb_stage.sv
// MEM/WB stage: byte-addressed data memory, load/store lane formatting, write-back select
// and the MEM/WB register, with a two-cycle split path for word-crossing accesses.
module mem_wb_stage #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned RD_W     = 5,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [1:0]      wb_ctrl,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      mem_ctrl,
    input  logic            reg_wr,
    input  logic [31:0]     pc_out,
    input  logic [31:0]     alu_out,
    input  logic [31:0]     mem_data,
    input  logic [RD_W-1:0] rd,
    output logic            stall,
    output logic [31:0]     wb_out,
    output logic [RD_W-1:0] rd_out,
    output logic            reg_wr_out,
    output logic            wb_valid,
    output logic            misalign_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned WORDS = 2 ** IDX_W;

    typedef enum logic [0:0] {StIdle, StSplit} state_e;

    state_e            r_state, w_state_d;
    logic [31:0]       r_mem [WORDS];
    logic [31:0]       r_lo;
    logic [31:0]       r_wb_out;
    logic [RD_W-1:0]   r_rd_out;
    logic              r_reg_wr_out;
    logic              r_wb_valid;
    logic              r_err;

    logic [IDX_W-1:0]  w_idx0, w_idx1;
    logic [1:0]        w_off;
    logic              w_mem_op;
    logic [7:0]        w_size_mask, w_mask8;
    logic              w_cross;
    logic [63:0]       w_sdata;
    logic [3:0]        w_be0, w_be1, w_we0, w_we1;
    logic              w_accept, w_err, w_lo_cap;
    logic [31:0]       w_rd0, w_rd1, w_lo;
    logic [63:0]       w_pair;
    logic [31:0]       w_ld_raw, w_load, w_wb_val;

    assign w_off    = alu_out[1:0];
    assign w_idx0   = alu_out[ADDR_W-1:2];
    assign w_idx1   = w_idx0 + IDX_W'(1);
    assign w_mem_op = mem_rd | mem_wr;

    always_comb begin
        case (mem_ctrl[1:0])
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            default: w_size_mask = 8'h0F;
        endcase
    end

    // Lanes [3:0] belong to the addressed word, lanes [7:4] spill into the next one.
    assign w_mask8 = w_size_mask << w_off;
    assign w_cross = w_mem_op & (|w_mask8[7:4]);
    assign w_sdata = {32'h0, mem_data} << {w_off, 3'b000};

    always_comb begin
        w_state_d = r_state;
        stall     = 1'b0;
        w_accept  = 1'b0;
        w_err     = 1'b0;
        w_lo_cap  = 1'b0;
        w_be0     = 4'h0;
        w_be1     = 4'h0;
        case (r_state)
            StIdle: begin
                if (valid_in) begin
                    if (!w_cross) begin
                        w_accept = 1'b1;
                        if (mem_wr) w_be0 = w_mask8[3:0];
                    end else if (SPLIT_EN) begin
                        stall     = 1'b1;
                        w_lo_cap  = 1'b1;
                        w_state_d = StSplit;
                        if (mem_wr) w_be0 = w_mask8[3:0];
                    end else begin
                        w_accept = 1'b1;
                        w_err    = 1'b1;
                    end
                end
            end
            StSplit: begin
                w_state_d = StIdle;
                if (valid_in) begin
                    w_accept = 1'b1;
                    if (mem_wr) w_be1 = w_mask8[7:4];
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_we0 = w_be0 & {4{~rst}};
    assign w_we1 = w_be1 & {4{~rst}};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we0[i]) r_mem[w_idx0][8*i +: 8] <= w_sdata[8*i +: 8];
            if (w_we1[i]) r_mem[w_idx1][8*i +: 8] <= w_sdata[32+8*i +: 8];
        end
    end

    // Reads are sampled into the MEM/WB register at the write edge, so they see pre-write data;
    // in SPLIT the low word comes from the copy captured before its half of the store landed.
    assign w_rd0    = r_mem[w_idx0];
    assign w_rd1    = r_mem[w_idx1];
    assign w_lo     = (r_state == StSplit) ? r_lo : w_rd0;
    assign w_pair   = {w_rd1, w_lo};
    assign w_ld_raw = w_pair[{w_off, 3'b000} +: 32];

    always_comb begin
        case (mem_ctrl)
            3'b000:  w_load = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            3'b001:  w_load = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            3'b100:  w_load = {24'h0, w_ld_raw[7:0]};
            3'b101:  w_load = {16'h0, w_ld_raw[15:0]};
            default: w_load = w_ld_raw;
        endcase
    end

    always_comb begin
        case (wb_ctrl)
            2'b00:   w_wb_val = pc_out;
            2'b01:   w_wb_val = alu_out;
            2'b10:   w_wb_val = w_load;
            default: w_wb_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_lo         <= '0;
            r_wb_out     <= '0;
            r_rd_out     <= '0;
            r_reg_wr_out <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_wb_valid   <= w_accept;
            r_err        <= w_accept & w_err;
            r_reg_wr_out <= w_accept & reg_wr & (|rd) & ~w_err;
            if (w_lo_cap) r_lo <= w_rd0;
            if (w_accept) begin
                r_wb_out <= w_err ? 32'h0 : w_wb_val;
                r_rd_out <= rd;
            end
        end
    end

    assign wb_out       = r_wb_out;
    assign rd_out       = r_rd_out;
    assign reg_wr_out   = r_reg_wr_out;
    assign wb_valid     = r_wb_valid;
    assign misalign_err = r_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: one split-enabled and one error-flag instance,
// directed vectors pushed as expectations, monitors pop on wb_valid.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb_ctrl;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_ctrl;
        logic        reg_wr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  rd;
    } req_t;

    typedef struct packed {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rwe;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    req_t req_s = '0;
    req_t req_n = '0;

    logic        s_stall, s_reg_wr_out, s_wb_valid, s_err;
    logic [31:0] s_wb_out;
    logic [4:0]  s_rd_out;
    logic        n_stall, n_reg_wr_out, n_wb_valid, n_err;
    logic [31:0] n_wb_out;
    logic [4:0]  n_rd_out;

    exp_t q_s[$];
    exp_t q_n[$];
    exp_t ms_got, ms_exp, mn_got, mn_exp;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_W(12), .RD_W(5), .SPLIT_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .valid_in(req_s.valid), .wb_ctrl(req_s.wb_ctrl),
        .mem_rd(req_s.mem_rd), .mem_wr(req_s.mem_wr), .mem_ctrl(req_s.mem_ctrl),
        .reg_wr(req_s.reg_wr), .pc_out(req_s.pc), .alu_out(req_s.alu),
        .mem_data(req_s.data), .rd(req_s.rd), .stall(s_stall), .wb_out(s_wb_out),
        .rd_out(s_rd_out), .reg_wr_out(s_reg_wr_out), .wb_valid(s_wb_valid),
        .misalign_err(s_err)
    );

    mem_wb_stage #(.ADDR_W(12), .RD_W(5), .SPLIT_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .valid_in(req_n.valid), .wb_ctrl(req_n.wb_ctrl),
        .mem_rd(req_n.mem_rd), .mem_wr(req_n.mem_wr), .mem_ctrl(req_n.mem_ctrl),
        .reg_wr(req_n.reg_wr), .pc_out(req_n.pc), .alu_out(req_n.alu),
        .mem_data(req_n.data), .rd(req_n.rd), .stall(n_stall), .wb_out(n_wb_out),
        .rd_out(n_rd_out), .reg_wr_out(n_reg_wr_out), .wb_valid(n_wb_valid),
        .misalign_err(n_err)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && s_wb_valid) begin
            ms_got = '{s_wb_out, s_rd_out, s_reg_wr_out, s_err};
            if (q_s.size() == 0) chk("s_unexpected_output", 64'(ms_got), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                ms_exp = q_s.pop_front();
                chk("s_wb{wb,rd,we,err}", 64'(ms_got), 64'(ms_exp));
            end
        end
        if (!rst && n_wb_valid) begin
            mn_got = '{n_wb_out, n_rd_out, n_reg_wr_out, n_err};
            if (q_n.size() == 0) chk("n_unexpected_output", 64'(mn_got), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                mn_exp = q_n.pop_front();
                chk("n_wb{wb,rd,we,err}", 64'(mn_got), 64'(mn_exp));
            end
        end
    end

    function automatic req_t mk(input logic [1:0] wbc, input logic rd_en, input logic wr_en,
                                input logic [2:0] ctl, input logic rwe, input logic [31:0] pc,
                                input logic [31:0] alu, input logic [31:0] dat,
                                input logic [4:0] rdi);
        req_t r;
        r = '{1'b1, wbc, rd_en, wr_en, ctl, rwe, pc, alu, dat, rdi};
        return r;
    endfunction

    function automatic exp_t mke(input logic [31:0] wb, input logic [4:0] rdi, input logic rwe,
                                 input logic err);
        exp_t e;
        e = '{wb, rdi, rwe, err};
        return e;
    endfunction

    // Drive a request (sel: 0 = split DUT, 1 = error-flag DUT) until accepted, counting stalls.
    task automatic issue(input bit sel, input string name, input req_t r, input int exp_stall,
                         input exp_t e);
        int  stalls;
        bit  accepted;
        logic st;
        stalls   = 0;
        accepted = 1'b0;
        if (sel) begin req_n = r; q_n.push_back(e); end
        else begin req_s = r; q_s.push_back(e); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            st = sel ? n_stall : s_stall;
            @(posedge clk);
            #1;
            if (!st) begin
                accepted = 1'b1;
                break;
            end
            stalls++;
        end
        chk({name, "_stall_cycles"}, accepted ? 64'(stalls) : 64'hDEAD, 64'(exp_stall));
    endtask

    task automatic store(input bit sel, input string name, input logic [2:0] ctl,
                         input logic [31:0] addr, input logic [31:0] dat, input int stalls);
        issue(sel, name, mk(2'b01, 1'b0, 1'b1, ctl, 1'b0, 32'h0, addr, dat, 5'd0), stalls,
              mke(addr, 5'd0, 1'b0, 1'b0));
    endtask

    task automatic load(input bit sel, input string name, input logic [2:0] ctl,
                        input logic [31:0] addr, input logic [4:0] rdi, input int stalls,
                        input logic [31:0] exp_data);
        issue(sel, name, mk(2'b10, 1'b1, 1'b0, ctl, 1'b1, 32'h0, addr, 32'h0, rdi), stalls,
              mke(exp_data, rdi, rdi != 5'd0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("s_reset_outputs", {s_wb_valid, s_wb_out, s_rd_out, s_reg_wr_out, s_err, s_stall}, 0);
        chk("n_reset_outputs", {n_wb_valid, n_wb_out, n_rd_out, n_reg_wr_out, n_err, n_stall}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Aligned traffic and load formatting on the split-enabled instance.
        store(0, "s_sw_010", 3'b010, 32'h010, 32'hDEADBEEF, 0);
        load(0, "s_lw_010", 3'b010, 32'h010, 5'd3, 0, 32'hDEADBEEF);
        load(0, "s_lb_013", 3'b000, 32'h013, 5'd4, 0, 32'hFFFFFFDE);
        load(0, "s_lbu_013", 3'b100, 32'h013, 5'd4, 0, 32'h000000DE);
        load(0, "s_lh_010", 3'b001, 32'h010, 5'd6, 0, 32'hFFFFBEEF);
        req_s = '0;
        @(negedge clk);
        @(negedge clk);
        chk("s_idle_hold", {s_wb_valid, s_reg_wr_out, s_wb_out, s_rd_out},
            {1'b0, 1'b0, 32'hFFFFBEEF, 5'd6});
        @(posedge clk);
        #1;

        // Word-crossing store/load via the split path.
        store(0, "s_sw_014", 3'b010, 32'h014, 32'h55667788, 0);
        store(0, "s_sw_012_split", 3'b010, 32'h012, 32'h11223344, 1);
        load(0, "s_lw_012_split", 3'b010, 32'h012, 5'd1, 1, 32'h11223344);
        load(0, "s_lw_010_after", 3'b010, 32'h010, 5'd2, 0, 32'h3344BEEF);
        load(0, "s_lw_014_after", 3'b010, 32'h014, 5'd2, 0, 32'h55661122);
        load(0, "s_lh_011", 3'b001, 32'h011, 5'd8, 0, 32'h000044BE);

        // Address wrap from the top word into word 0.
        store(0, "s_sw_ffc", 3'b010, 32'hFFC, 32'hA1B2C3D4, 0);
        store(0, "s_sw_000", 3'b010, 32'h000, 32'h0F0E0D0C, 0);
        load(0, "s_lh_fff_wrap", 3'b001, 32'hFFF, 5'd9, 1, 32'h00000CA1);

        // Write-back source select and rd=0 suppression.
        issue(0, "s_wbsel_pc", mk(2'b00, 1'b0, 1'b0, 3'b010, 1'b1, 32'h1234, 32'h5678, 32'h0,
              5'd7), 0, mke(32'h1234, 5'd7, 1'b1, 1'b0));
        issue(0, "s_wbsel_alu", mk(2'b01, 1'b0, 1'b0, 3'b010, 1'b1, 32'h1234, 32'h5678, 32'h0,
              5'd7), 0, mke(32'h5678, 5'd7, 1'b1, 1'b0));
        issue(0, "s_wbsel_zero", mk(2'b11, 1'b0, 1'b0, 3'b010, 1'b1, 32'h1234, 32'h5678, 32'h0,
              5'd7), 0, mke(32'h0, 5'd7, 1'b1, 1'b0));
        issue(0, "s_rd0", mk(2'b01, 1'b0, 1'b0, 3'b010, 1'b1, 32'h1234, 32'h5678, 32'h0,
              5'd0), 0, mke(32'h5678, 5'd0, 1'b0, 1'b0));

        // Simultaneous read and write returns pre-write data.
        store(0, "s_sw_020", 3'b010, 32'h020, 32'h01020304, 0);
        issue(0, "s_rdwr_020", mk(2'b10, 1'b1, 1'b1, 3'b010, 1'b1, 32'h0, 32'h020, 32'hCAFEF00D,
              5'd10), 0, mke(32'h01020304, 5'd10, 1'b1, 1'b0));
        load(0, "s_lw_020", 3'b010, 32'h020, 5'd10, 0, 32'hCAFEF00D);

        // Reset in the middle of a split store.
        store(0, "s_sw_030", 3'b010, 32'h030, 32'hAAAAAAAA, 0);
        issue(0, "s_sw_034", mk(2'b01, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0, 32'h034, 32'hBBBBBBBB,
              5'd9), 0, mke(32'h034, 5'd9, 1'b0, 1'b0));
        req_s = '0;
        repeat (3) @(posedge clk);
        #1;
        req_s = mk(2'b01, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0, 32'h031, 32'h99887766, 5'd0);
        @(negedge clk);
        chk("s_split_store_stall", 64'(s_stall), 64'd1);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        req_s = '0;
        #1;
        chk("s_rst_mid_split", {s_wb_valid, s_wb_out, s_rd_out, s_reg_wr_out, s_err, s_stall}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        load(0, "s_lw_030_rst", 3'b010, 32'h030, 5'd11, 0, 32'h887766AA);
        load(0, "s_lw_034_rst", 3'b010, 32'h034, 5'd11, 0, 32'hBBBBBBBB);
        req_s = '0;

        // Error-flag instance: crossing accesses are suppressed.
        store(1, "n_sw_010", 3'b010, 32'h010, 32'hDEADBEEF, 0);
        store(1, "n_sw_014", 3'b010, 32'h014, 32'h77777777, 0);
        issue(1, "n_lw_011_err", mk(2'b10, 1'b1, 1'b0, 3'b010, 1'b1, 32'h0, 32'h011, 32'h0,
              5'd5), 0, mke(32'h0, 5'd5, 1'b0, 1'b1));
        load(1, "n_lw_010", 3'b010, 32'h010, 5'd3, 0, 32'hDEADBEEF);
        issue(1, "n_sw_013_err", mk(2'b01, 1'b0, 1'b1, 3'b010, 1'b1, 32'h0, 32'h013,
              32'h12345678, 5'd6), 0, mke(32'h0, 5'd6, 1'b0, 1'b1));
        load(1, "n_lw_010_unch", 3'b010, 32'h010, 5'd3, 0, 32'hDEADBEEF);
        load(1, "n_lw_014_unch", 3'b010, 32'h014, 5'd0, 0, 32'h77777777);
        store(1, "n_sh_012", 3'b001, 32'h012, 32'hFFFF5A5A, 0);
        load(1, "n_lw_010_sh", 3'b010, 32'h010, 5'd12, 0, 32'h5A5ABEEF);
        req_n = '0;

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q_s.size() + q_n.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised memory-access / write-back stage for the FyraVortex pipeline: byte-addressed data memory, load/store formatting, write-back select and an explicit MEM/WB pipeline register.
- Adds what the earlier stage lacks:
  - valid/stall handshake;
  - registered write-back outputs;
  - a 2-cycle split FSM for misaligned accesses that cross a word boundary, with an error-flag alternative.
- Sits between the EX/MEM register and the register file / forwarding unit.

Parameters:
ADDR_W, 12, byte-address width; memory holds 2**ADDR_W bytes as 2**(ADDR_W-2) 32-bit words.
RD_W, 5, destination register index width.
SPLIT_EN, 1, 1: misaligned crossing accesses take 2 cycles; 0: such accesses are suppressed and flagged.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
valid_in  in  1  request present this cycle; upstream holds all inputs while stall=1.
wb_ctrl  in  2  write-back source: 00 pc_out, 01 alu_out, 10 load data, 11 zero.
mem_rd  in  1  load request.
mem_wr  in  1  store request.
mem_ctrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are treated as W.
reg_wr  in  1  register write enable.
pc_out  in  32  link value (pc+4).
alu_out  in  32  effective address / ALU result; address = alu_out[ADDR_W-1:0].
mem_data  in  32  store data, right-aligned.
rd  in  RD_W  destination register.
stall  out  1  combinational; 1 = request not accepted this cycle.
wb_out  out  32  registered write-back value.
rd_out  out  RD_W  registered destination.
reg_wr_out  out  1  registered write enable.
wb_valid  out  1  registered; wb_* outputs are meaningful.
misalign_err  out  1  registered; 1-cycle pulse with wb_valid for a suppressed access (SPLIT_EN=0).

Behaviour:
- Reset: all outputs 0, FSM to IDLE. Memory contents are not reset. Reset mid-split aborts the split; a first-half store already written remains.
- Accept: edge where valid_in=1 and stall=0. Latency: wb_valid=1 in the cycle after acceptance, else 0. No bubbles for aligned traffic (one request per cycle).
- Access size: B=1, H=2, W=4 bytes.
  - Crossing when (addr[1:0] + size) > 4: W with addr[1:0]!=0, or H with addr[1:0]=3.
  - Non-crossing accesses complete in one cycle with byte enables derived from addr[1:0] and size.
- Memory: synchronous, byte-enabled write and synchronous read at the same edge. With mem_rd and mem_wr both set, the write is performed and the read returns pre-write contents.
- Load format: select bytes, then sign-extend (B/H) or zero-extend (BU/HU/W).
- Store: mem_data low bytes are shifted to the byte lanes; only the enabled lanes change.
- FSM (SPLIT_EN=1), states IDLE, SPLIT:
  - IDLE, crossing request: stall=1 and the first word (addr>>2) is accessed for the lower lanes; go to SPLIT.
  - SPLIT: stall=0; word ((addr>>2)+1) mod 2**(ADDR_W-2) is accessed for the remaining bytes; the request is accepted and the result assembled; return to IDLE. Address wraps modulo memory size.
- SPLIT_EN=0, crossing request:
  - accepted in 1 cycle; no memory write;
  - wb_out=0, reg_wr_out=0, misalign_err=1.
- reg_wr_out = reg_wr & (rd!=0) & no error. rd_out = rd.
- No request (valid_in=0): wb_valid=0 and reg_wr_out=0; wb_out/rd_out hold their previous values.
- A request with mem_rd=mem_wr=0 never touches memory and never stalls.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 wb_ctrl=10 -> wb_out=0xDEADBEEF one cycle after accept, wb_valid=1, stall never high.
- LB @0x013 then LBU @0x013 (byte 0xDE) -> wb_out=0xFFFFFFDE then 0x000000DE; LH @0x010 -> 0xFFFFBEEF.
- SPLIT_EN=1: SW 0x11223344 @0x012, LW @0x012 -> stall=1 for exactly one cycle per access; words 0x010/0x014 hold 0x3344BEEF / 0x????1122 (other lanes unchanged); load returns 0x11223344.
- Wrap: LH @0xFFF (ADDR_W=12) -> second word is index 0; assembled from byte 0xFFF (low) and byte 0x000 (high).
- SPLIT_EN=0: LW @0x011 reg_wr=1 rd=5 -> misalign_err=1, reg_wr_out=0, wb_out=0, memory unchanged; rd=0 with reg_wr=1 on a legal op -> reg_wr_out=0.
- Assert rst during SPLIT of a store -> outputs 0 immediately, FSM IDLE, only the first-half bytes are modified; wb_ctrl=00/01/11 -> pc_out/alu_out/0.
